counter_sweep_ctrl: RTL

Sequencing controller for the 4-bit up/down counter datapath. It owns a bounded up/down count register and steers its direction automatically. On a start handshake it sweeps the count lo -> hi -> lo for a programmed number of sweeps, then signals done. It sits between the control/host logic and any consumer of the count value, and adds pause, abort and configuration checking.

---
 rtl/counter_sweep_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//
// Sequencing controller for a bounded 4-bit up/down counter. When a start is
// accepted, the controller captures lo/hi/num_sweeps into shadow registers.
// It then sweeps the count lo -> hi -> lo num_sweeps times and pulses done.
// Pause freezes the run. Abort ends the run without a done pulse. A start
// with a bad configuration (lo >= hi or num_sweeps == 0) is rejected with a
// one-cycle cfg_err pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        sweep request, sampled only while idle
//   lo, hi       count bounds, captured at an accepted start
//   num_sweeps   number of lo->hi->lo sweeps, captured at an accepted start
//   pause        holds count/state/sweeps while busy
//   abort        ends the run while busy (priority over pause)
//   count        current count value
//   up_down      current direction (1 = up, 0 = down)
//   busy         high while a run is in progress
//   done         one-cycle pulse on normal completion
//   sweeps_done  completed sweeps in the current or last run
//   cfg_err      one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic               pause,
    input  logic               abort,
    output logic [WIDTH-1:0]   count,
    output logic               up_down,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweeps_done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0] SWP_ONE   = {{(SWEEP_W-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0] SWP_ZERO  = {SWEEP_W{1'b0}};
    localparam logic [WIDTH-1:0]   CNT_ZERO  = {WIDTH{1'b0}};

    state_t               state_r;
    logic [WIDTH-1:0]     lo_r;
    logic [WIDTH-1:0]     hi_r;
    logic [SWEEP_W-1:0]   num_r;

    logic                 cfg_bad_s;
    logic [SWEEP_W-1:0]   sweeps_next_s;
    logic                 last_sweep_s;

    // Configuration check on the live inputs and end-of-run detection on the shadows.
    always_comb begin
        cfg_bad_s     = 1'b0;
        sweeps_next_s = sweeps_done + SWP_ONE;
        last_sweep_s  = 1'b0;
        if ((lo >= hi) || (num_sweeps == SWP_ZERO)) begin
            cfg_bad_s = 1'b1;
        end else begin
            cfg_bad_s = 1'b0;
        end
        if (sweeps_next_s == num_r) begin
            last_sweep_s = 1'b1;
        end else begin
            last_sweep_s = 1'b0;
        end
    end

    // Sweep sequencer: state, shadow bounds and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            lo_r        <= CNT_ZERO;
            hi_r        <= CNT_ZERO;
            num_r       <= SWP_ZERO;
            count       <= CNT_ZERO;
            up_down     <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            sweeps_done <= SWP_ZERO;
            cfg_err     <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_bad_s) begin
                            cfg_err <= 1'b1;
                        end else begin
                            lo_r        <= lo;
                            hi_r        <= hi;
                            num_r       <= num_sweeps;
                            count       <= lo;
                            up_down     <= 1'b1;
                            sweeps_done <= SWP_ZERO;
                            busy        <= 1'b1;
                            state_r     <= ST_UP;
                        end
                    end
                end
                ST_UP: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (pause) begin
                        state_r <= ST_UP;
                    end else if (count != hi_r) begin
                        count <= count + CNT_ONE;
                    end else begin
                        // Turn around immediately: no dwell at the upper bound.
                        count   <= hi_r - CNT_ONE;
                        up_down <= 1'b0;
                        state_r <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (pause) begin
                        state_r <= ST_DOWN;
                    end else if (count != lo_r) begin
                        count <= count - CNT_ONE;
                    end else if (!last_sweep_s) begin
                        sweeps_done <= sweeps_next_s;
                        count       <= lo_r + CNT_ONE;
                        up_down     <= 1'b1;
                        state_r     <= ST_UP;
                    end else begin
                        // Final sweep complete: count rests at lo, direction stays down.
                        sweeps_done <= sweeps_next_s;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
